// File: rtl/roach_dram_pkg.sv
// roach_dram_pkg: widths and state encodings shared by the ROACH2 DRAM arbiter files.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package roach_dram_pkg;

  localparam int DATA_W    = 288;
  localparam int BE_W      = 36;
  localparam int CMD_TAG_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } side_t;

endpackage

// File: rtl/roach_dram_rr_arb.sv
// roach_dram_rr_arb: 2-way round-robin pointer plus read/write eligibility.
// Latency: selection is combinational; pointer updates on the cycle a command is acked.
// Backpressure: reads are ineligible while outstanding has reached MAX_OUTSTANDING.
module roach_dram_rr_arb
  import roach_dram_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             wr_mask,
  input  logic             rd_mask,
  input  logic [OUT_W-1:0] outstanding,
  input  logic             grant_vld,
  input  logic             grant_rd,
  output logic             sel_vld,
  output logic             sel_rd,
  output logic             rd_blocked
);

  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

  side_t ptr;
  logic  wr_elig;
  logic  rd_elig;

  // Eligibility and pick: pointer side wins a tie, a lone eligible side always wins.
  // A side whose gnt is pulsing this cycle is masked, since its req still shows the
  // request that was just served.
  always_comb begin
    rd_blocked = rd_req && (outstanding >= MAX_CNT);
    wr_elig    = wr_req && !wr_mask;
    rd_elig    = rd_req && !rd_mask && !rd_blocked;
    sel_vld    = wr_elig || rd_elig;
    sel_rd     = rd_elig && (!wr_elig || (ptr == SIDE_RD));
  end

  // Pointer moves to the side that was not just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SIDE_WR;
    end else if (grant_vld) begin
      ptr <= grant_rd ? SIDE_WR : SIDE_RD;
    end
  end

endmodule

// File: rtl/roach_dram_arbiter.sv
// roach_dram_arbiter: shares the ROACH2 DRAM command port between one writer and one reader.
// Latency: req in IDLE -> dram_cmd_valid 1 cycle; ack -> gnt 1 cycle; dram_rd_valid -> rd_data_valid 1 cycle.
// Backpressure: command held until dram_cmd_ack; reads throttled at MAX_OUTSTANDING; return path never stalls.
// Optional: define ROACH_DRAM_ARBITER_STATS_EN for wr_count / rd_count / stall_count outputs.
module roach_dram_arbiter
  import roach_dram_pkg::*;
#(
  parameter int DRAM_ADDR       = 25,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               phy_ready,
  input  logic                               wr_req,
  input  logic [DRAM_ADDR-1:0]               wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [BE_W-1:0]                    wr_be,
  output logic                               wr_gnt,
  input  logic                               rd_req,
  input  logic [DRAM_ADDR-1:0]               rd_addr,
  output logic                               rd_gnt,
  output logic [DRAM_ADDR-1:0]               dram_addr,
  output logic [DATA_W-1:0]                  dram_data,
  output logic [BE_W-1:0]                    dram_wr_be,
  output logic                               dram_rwn,
  output logic [CMD_TAG_W-1:0]               dram_cmd_tag,
  output logic                               dram_cmd_valid,
  input  logic                               dram_cmd_ack,
  input  logic                               dram_rd_valid,
  input  logic [CMD_TAG_W-1:0]               dram_rd_tag,
  input  logic [DATA_W-1:0]                  dram_rd_data,
  output logic [DATA_W-1:0]                  rd_data,
  output logic [TAG_W-1:0]                   rd_data_tag,
  output logic                               rd_data_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
`ifdef ROACH_DRAM_ARBITER_STATS_EN
  ,
  output logic [31:0]                        wr_count,
  output logic [31:0]                        rd_count,
  output logic [31:0]                        stall_count
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  state_t     state;
  state_t     state_nxt;
  logic       load;
  logic       ack_fire;
  logic       sel_vld;
  logic       sel_rd;
  logic       rd_blocked;
  logic       rd_inc;
  logic       rd_dec;
  logic [TAG_W-1:0] tag_cnt;
  logic       rd_tag_unused;

  // Only the low TAG_W bits of the returned tag are forwarded.
  assign rd_tag_unused = ^dram_rd_tag;

  roach_dram_rr_arb #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OUT_W           (OUT_W)
  ) u_rr_arb (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .wr_mask     (wr_gnt),
    .rd_mask     (rd_gnt),
    .outstanding (outstanding),
    .grant_vld   (ack_fire),
    .grant_rd    (dram_rwn),
    .sel_vld     (sel_vld),
    .sel_rd      (sel_rd),
    .rd_blocked  (rd_blocked)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a held command is never retracted, even if phy_ready drops.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (phy_ready && sel_vld) state_nxt = ISSUE;
      ISSUE: if (dram_cmd_ack)         state_nxt = IDLE;
    endcase
  end

  // FSM outputs: command valid, command capture strobe and ack strobe.
  always_comb begin
    dram_cmd_valid = (state == ISSUE);
    load           = (state == IDLE) && phy_ready && sel_vld;
    ack_fire       = (state == ISSUE) && dram_cmd_ack;
  end

  // Command fields are captured on the IDLE->ISSUE transition and held until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dram_addr    <= '0;
      dram_data    <= '0;
      dram_wr_be   <= '0;
      dram_rwn     <= 1'b1;
      dram_cmd_tag <= '0;
    end else if (load) begin
      dram_rwn     <= sel_rd;
      dram_addr    <= sel_rd ? rd_addr : wr_addr;
      dram_data    <= sel_rd ? '0 : wr_data;
      dram_wr_be   <= sel_rd ? '0 : wr_be;
      dram_cmd_tag <= sel_rd ? CMD_TAG_W'(tag_cnt) : '0;
    end
  end

  // Grant pulses, one cycle after the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_gnt <= 1'b0;
      rd_gnt <= 1'b0;
    end else begin
      wr_gnt <= ack_fire && !dram_rwn;
      rd_gnt <= ack_fire && dram_rwn;
    end
  end

  // Outstanding bookkeeping; a return with nothing outstanding does not underflow.
  always_comb begin
    rd_inc = ack_fire && dram_rwn;
    rd_dec = dram_rd_valid && (outstanding != '0);
  end

  // Read tag counter and outstanding count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (rd_inc) tag_cnt <= tag_cnt + 1'b1;
      case ({rd_inc, rd_dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Return path register stage, arrival order preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data       <= '0;
      rd_data_tag   <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= dram_rd_valid;
      if (dram_rd_valid) begin
        rd_data     <= dram_rd_data;
        rd_data_tag <= dram_rd_tag[TAG_W-1:0];
      end
    end
  end

`ifdef ROACH_DRAM_ARBITER_STATS_EN
  // Acked command counters and read stall counter, all wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count    <= '0;
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (ack_fire && !dram_rwn) wr_count <= wr_count + 32'd1;
      if (ack_fire && dram_rwn)  rd_count <= rd_count + 32'd1;
      if (rd_blocked)            stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic stall_unused;
  assign stall_unused = rd_blocked;
`endif

endmodule

// File: tb/tb_roach_dram_arbiter.sv
// tb_roach_dram_arbiter: directed stimulus with a scoreboard for commands and return data.
// Latency: checks 1-cycle issue, ack->gnt and return register timing.
// Backpressure: bench acks commands after a programmable number of valid cycles.
module tb_roach_dram_arbiter;
  import roach_dram_pkg::*;

  typedef struct {
    logic [24:0]  addr;
    logic [287:0] data;
    logic [35:0]  be;
    logic [31:0]  tag;
  } cmd_t;

  typedef struct {
    logic [287:0] data;
    logic [7:0]   tag;
    longint       due;
  } ret_t;

  logic         clk = 1'b0;
  logic         rst, phy_ready;
  logic         wr_req, rd_req, wr_gnt, rd_gnt;
  logic [24:0]  wr_addr, rd_addr, dram_addr;
  logic [287:0] wr_data, dram_data, dram_rd_data, rd_data;
  logic [35:0]  wr_be, dram_wr_be;
  logic         dram_rwn, dram_cmd_valid, dram_cmd_ack, dram_rd_valid, rd_data_valid;
  logic [31:0]  dram_cmd_tag, dram_rd_tag;
  logic [7:0]   rd_data_tag;
  logic [3:0]   outstanding;
`ifdef ROACH_DRAM_ARBITER_STATS_EN
  logic [31:0]  wr_count, rd_count, stall_count;
`endif

  roach_dram_arbiter #(.DRAM_ADDR(25), .MAX_OUTSTANDING(8), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .phy_ready(phy_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .dram_addr(dram_addr), .dram_data(dram_data), .dram_wr_be(dram_wr_be), .dram_rwn(dram_rwn),
    .dram_cmd_tag(dram_cmd_tag), .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ack(dram_cmd_ack),
    .dram_rd_valid(dram_rd_valid), .dram_rd_tag(dram_rd_tag), .dram_rd_data(dram_rd_data),
    .rd_data(rd_data), .rd_data_tag(rd_data_tag), .rd_data_valid(rd_data_valid),
    .outstanding(outstanding)
`ifdef ROACH_DRAM_ARBITER_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count), .stall_count(stall_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int     total = 0, bad = 0;
  longint cyc = 0;
  cmd_t   wr_q[$], rd_q[$], exp_wr[$], exp_rd[$];
  ret_t   exp_ret[$];
  logic [7:0] ret_q[$];
  logic   order_log[$];
  int     n_wr_gnt = 0, n_rd_gnt = 0, ncmd = 0, last_run = 0, run = 0, ack_n = 1;
  bit     auto_ack = 1, auto_ret = 0, wrapped = 0, seen_rd = 0, prev_vld = 0;
  logic [7:0] prev_rtag = '0, last_cmd_tag = '0, tag_model = '0;
  cmd_t   cur;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] mkdata(input logic [7:0] t);
    logic [31:0] w;
    w = {24'hA5C3E1, t};
    return {9{w}};
  endfunction

  function automatic logic [287:0] wdata(input logic [24:0] a);
    logic [31:0] w;
    w = {7'b1010101, a};
    return {9{w}};
  endfunction

  task automatic queue_wr(input logic [24:0] a, input logic [35:0] be);
    cmd_t c;
    c.addr = a; c.data = wdata(a); c.be = be; c.tag = '0;
    wr_q.push_back(c);
    exp_wr.push_back(c);
  endtask

  task automatic queue_rd(input logic [24:0] a);
    cmd_t c;
    c.addr = a; c.data = '0; c.be = '0; c.tag = {24'h0, tag_model};
    tag_model = tag_model + 8'd1;
    rd_q.push_back(c);
    exp_rd.push_back(c);
  endtask

  task automatic ret_one(input logic [7:0] t, input logic [23:0] hi);
    ret_t r;
    dram_rd_valid = 1'b1; dram_rd_tag = {hi, t}; dram_rd_data = mkdata(t);
    r.data = mkdata(t); r.tag = t; r.due = cyc + 1;
    exp_ret.push_back(r);
    @(negedge clk);
    dram_rd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while (n < budget && !(wr_q.size() == 0 && rd_q.size() == 0 && !wr_req && !rd_req &&
           !dram_cmd_valid && ret_q.size() == 0 && exp_ret.size() == 0 && !dram_rd_valid)) begin
      @(negedge clk);
      n++;
    end
    chk(name, 288'(n < budget), 288'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!dram_cmd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 288'(dram_cmd_valid), 288'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_q.delete(); rd_q.delete(); exp_wr.delete(); exp_rd.delete();
    exp_ret.delete(); ret_q.delete();
    tag_model = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Write requester: hold until gnt, then present the next queued write.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (wr_req && wr_gnt) wr_req = 1'b0;
      if (!wr_req && !rst && wr_q.size() > 0) begin
        c = wr_q.pop_front();
        wr_addr = c.addr; wr_data = c.data; wr_be = c.be; wr_req = 1'b1;
      end
    end
  end

  // Read requester.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (rd_req && rd_gnt) rd_req = 1'b0;
      if (!rd_req && !rst && rd_q.size() > 0) begin
        c = rd_q.pop_front();
        rd_addr = c.addr; rd_req = 1'b1;
      end
    end
  end

  // DRAM command acker: ack in the ack_n-th valid cycle.
  initial begin
    int vcnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !dram_cmd_valid) begin
        vcnt = 0; dram_cmd_ack = 1'b0;
      end else if (auto_ack) begin
        vcnt++;
        dram_cmd_ack = (vcnt >= ack_n);
      end else begin
        dram_cmd_ack = 1'b0;
      end
    end
  end

  // Prompt read returner, one word per cycle for each granted read.
  initial begin
    logic [7:0] t;
    ret_t r;
    forever begin
      @(negedge clk);
      if (auto_ret) begin
        if (ret_q.size() > 0) begin
          t = ret_q.pop_front();
          dram_rd_valid = 1'b1; dram_rd_tag = {24'hC0FFEE, t}; dram_rd_data = mkdata(t);
          r.data = mkdata(t); r.tag = t; r.due = cyc + 1;
          exp_ret.push_back(r);
        end else begin
          dram_rd_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: command bus, grants and return path against the scoreboard.
  initial begin
    cmd_t e;
    ret_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 0;
      end else begin
        if (dram_cmd_valid && !prev_vld) begin
          ncmd++; run = 1;
          order_log.push_back(dram_rwn);
          cur.addr = dram_addr; cur.data = dram_data; cur.be = dram_wr_be; cur.tag = dram_cmd_tag;
          if (dram_rwn) begin
            chk("rd_cmd_expected", 288'(exp_rd.size() != 0), 288'(1));
            if (exp_rd.size() != 0) begin
              e = exp_rd.pop_front();
              chk("rd_addr", 288'(dram_addr), 288'(e.addr));
              chk("rd_be", 288'(dram_wr_be), 288'(0));
              chk("rd_tag", 288'(dram_cmd_tag), 288'(e.tag));
            end
            if (seen_rd && prev_rtag == 8'hFF && dram_cmd_tag[7:0] == 8'h00) wrapped = 1;
            prev_rtag = dram_cmd_tag[7:0]; seen_rd = 1;
            last_cmd_tag = dram_cmd_tag[7:0];
          end else begin
            chk("wr_cmd_expected", 288'(exp_wr.size() != 0), 288'(1));
            if (exp_wr.size() != 0) begin
              e = exp_wr.pop_front();
              chk("wr_addr", 288'(dram_addr), 288'(e.addr));
              chk("wr_data", dram_data, e.data);
              chk("wr_be", 288'(dram_wr_be), 288'(e.be));
              chk("wr_tag", 288'(dram_cmd_tag), 288'(0));
            end
          end
        end else if (dram_cmd_valid) begin
          run++;
          chk("cmd_stable", 288'(dram_addr == cur.addr && dram_data == cur.data &&
              dram_wr_be == cur.be && dram_cmd_tag == cur.tag), 288'(1));
        end else if (prev_vld) begin
          last_run = run;
        end
        prev_vld = dram_cmd_valid;

        if (wr_gnt) n_wr_gnt++;
        if (rd_gnt) begin
          n_rd_gnt++;
          if (auto_ret) ret_q.push_back(last_cmd_tag);
        end

        if (rd_data_valid) begin
          chk("ret_expected", 288'(exp_ret.size() != 0), 288'(1));
          if (exp_ret.size() != 0) begin
            r = exp_ret.pop_front();
            chk("ret_data", rd_data, r.data);
            chk("ret_tag", 288'(rd_data_tag), 288'(r.tag));
            chk("ret_cycle", 288'(cyc), 288'(r.due));
          end
        end else if (exp_ret.size() != 0 && exp_ret[0].due < cyc) begin
          chk("ret_valid", 288'(rd_data_valid), 288'(1));
          void'(exp_ret.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int base_w, base_r, saved;
    rst = 1'b1; phy_ready = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    dram_cmd_ack = 1'b0; dram_rd_valid = 1'b0; dram_rd_tag = '0; dram_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 288'(dram_cmd_valid), 288'(0));
    chk("rst_rwn", 288'(dram_rwn), 288'(1));
    chk("rst_outstanding", 288'(outstanding), 288'(0));
    chk("rst_gnts", 288'({wr_gnt, rd_gnt}), 288'(0));
    chk("rst_rd_data_valid", 288'(rd_data_valid), 288'(0));
    chk("rst_addr", 288'(dram_addr), 288'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single write, ack in the 3rd valid cycle.
    ack_n = 3; order_log.delete(); base_w = n_wr_gnt;
    queue_wr(25'h10, 36'hF_FFFF_FFFF);
    wait_quiet("t1_quiet", 100);
    chk("t1_valid_cycles", 288'(last_run), 288'(3));
    chk("t1_wr_gnt_count", 288'(n_wr_gnt - base_w), 288'(1));
    chk("t1_rwn", 288'(order_log[0]), 288'(0));
    chk("t1_outstanding", 288'(outstanding), 288'(0));

    // Both requesters continuously busy, immediate acks: W,R,W,R...
    do_reset();
    ack_n = 1; order_log.delete();
    for (int i = 0; i < 4; i++) begin
      queue_wr(25'h100 + 25'(i), 36'h1_2345_6789);
      queue_rd(25'h200 + 25'(i));
    end
    wait_quiet("t2_quiet", 200);
    chk("t2_cmd_count", 288'(order_log.size()), 288'(8));
    for (int i = 0; i < 8 && i < order_log.size(); i++)
      chk("t2_order", 288'(order_log[i]), 288'(i % 2));
    chk("t2_outstanding", 288'(outstanding), 288'(4));
    for (int i = 0; i < 4; i++) ret_one(8'(i), 24'h5A5A00);
    repeat (2) @(negedge clk);
    chk("t2_outstanding_drained", 288'(outstanding), 288'(0));

    // Read throttling at MAX_OUTSTANDING; writes unaffected.
    base_w = n_wr_gnt; base_r = n_rd_gnt;
    for (int i = 0; i < 9; i++) queue_rd(25'h300 + 25'(i));
    queue_wr(25'h0ABCDE, 36'h0_0000_FFFF);
    repeat (80) @(negedge clk);
    chk("t3_rd_gnts_stalled", 288'(n_rd_gnt - base_r), 288'(8));
    chk("t3_outstanding_max", 288'(outstanding), 288'(8));
    chk("t3_wr_gnt", 288'(n_wr_gnt - base_w), 288'(1));
    chk("t3_rd_req_waiting", 288'(rd_req), 288'(1));
`ifdef ROACH_DRAM_ARBITER_STATS_EN
    chk("t3_stall_count_nonzero", 288'(stall_count != 0), 288'(1));
`endif
    ret_one(8'd4, 24'h000001);
    repeat (10) @(negedge clk);
    chk("t3_one_more_read", 288'(n_rd_gnt - base_r), 288'(9));
    chk("t3_outstanding_refill", 288'(outstanding), 288'(8));

    // Same-cycle read ack and return at outstanding=5.
    for (int i = 5; i < 8; i++) ret_one(8'(i), 24'h000002);
    @(negedge clk);
    chk("t4_outstanding_5", 288'(outstanding), 288'(5));
    queue_rd(25'h3F0);
    wait_valid("t4_valid", 50);
    ret_one(8'd8, 24'hDEAD00);
    chk("t4_outstanding_same", 288'(outstanding), 288'(5));
    wait_quiet("t4_quiet", 50);

    // phy_ready gating.
    phy_ready = 1'b0;
    saved = ncmd;
    queue_wr(25'h1ABCDEF, 36'hA_5A5A_5A5A);
    repeat (6) @(negedge clk);
    chk("t5_no_cmd_count", 288'(ncmd - saved), 288'(0));
    chk("t5_no_cmd_valid", 288'(dram_cmd_valid), 288'(0));
    phy_ready = 1'b1;
    @(negedge clk);
    chk("t5_cmd_after_ready", 288'(dram_cmd_valid), 288'(1));
    wait_quiet("t5_quiet", 50);

    // Reset while a read command is held.
    auto_ack = 0;
    queue_rd(25'h155);
    wait_valid("t5_rst_valid", 50);
    chk("t5_outstanding_pre", 288'(outstanding), 288'(5));
    rst = 1'b1;
    #1;
    chk("t5_rst_cmd_valid", 288'(dram_cmd_valid), 288'(0));
    chk("t5_rst_outstanding", 288'(outstanding), 288'(0));
    chk("t5_rst_rwn", 288'(dram_rwn), 288'(1));
    @(negedge clk);
    do_reset();
    auto_ack = 1;

    // 300 reads with prompt returns; tag wraps 255->0.
    auto_ret = 1; seen_rd = 0; wrapped = 0; base_r = n_rd_gnt;
    for (int i = 0; i < 300; i++) queue_rd(25'h40000 + 25'(i));
    wait_quiet("t6_quiet", 3000);
    auto_ret = 0;
    chk("t6_rd_gnts", 288'(n_rd_gnt - base_r), 288'(300));
    chk("t6_tag_wrapped", 288'(wrapped), 288'(1));
    chk("t6_last_tag", 288'(last_cmd_tag), 288'(8'd43));
    chk("t6_outstanding", 288'(outstanding), 288'(0));
`ifdef ROACH_DRAM_ARBITER_STATS_EN
    chk("t6_rd_count", 288'(rd_count), 288'(300));
    chk("t6_wr_count", 288'(wr_count), 288'(0));
`endif

    chk("end_exp_wr_empty", 288'(exp_wr.size()), 288'(0));
    chk("end_exp_rd_empty", 288'(exp_rd.size()), 288'(0));
    chk("end_exp_ret_empty", 288'(exp_ret.size()), 288'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
